// File: rtl/vip_pkg.sv
// Shared types and constants for the video capture path.
package vip_pkg;

  localparam int unsigned DEF_HDISP = 640;
  localparam int unsigned DEF_VDISP = 480;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned PIX_BYTES = 3;
  localparam int unsigned PIX_W     = BYTE_W * PIX_BYTES;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned POS_W     = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    ACTIVE = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } cap_state_e;

endpackage

// File: rtl/rgb24_word_packer.sv
// Packs 3-byte pixels into a little-endian 32-bit word stream; holds up to 3 residual bytes.
module rgb24_word_packer
  import vip_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              pix_valid_i,
  input  logic [PIX_W-1:0]  pix_i,
  input  logic              flush_i,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned CAT_W = WORD_W + PIX_W;

  logic [PIX_W-1:0] acc_q, acc_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_le;
  logic [CAT_W-1:0] cat;

  // Append the pixel's bytes above the residual bytes and emit a word once 4 are held.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    word_valid_c = 1'b0;
    word_c       = '0;
    // bits [23:16] are the first byte in memory, so they land lowest in the word
    pix_le = {pix_i[7:0], pix_i[15:8], pix_i[23:16]};
    cat    = CAT_W'(acc_q) | (CAT_W'(pix_le) << {cnt_q, 3'b000});
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (pix_valid_i) begin
      if (cnt_q != 2'd0) begin
        word_valid_c = 1'b1;
        word_c       = cat[WORD_W-1:0];
        acc_d        = cat[CAT_W-1:WORD_W];
        cnt_d        = 2'(cnt_q - 2'd1);
      end else begin
        acc_d = cat[PIX_W-1:0];
        cnt_d = 2'd3;
      end
    end else if (flush_i) begin
      // residual bytes go out zero-padded; upper bits of acc_q are always zero
      word_valid_c = (cnt_q != 2'd0);
      word_c       = WORD_W'(acc_q);
      acc_d        = '0;
      cnt_d        = '0;
    end
  end

  // Residual byte and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_frame_capture.sv
// Captures one video frame into word memory as a packed 3-byte-per-pixel stream.
module video_frame_capture
  import vip_pkg::*;
#(
  parameter int unsigned IMG_HDISP = DEF_HDISP,
  parameter int unsigned IMG_VDISP = DEF_VDISP,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [PIX_W-1:0]  pix_data_in,
  input  logic              cap_start,
  input  logic              cap_continuous,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [POS_W-1:0]  x_pos,
  output logic [POS_W-1:0]  y_pos,
  output logic              cap_busy,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err
);

  localparam logic [POS_W-1:0]  H_END     = POS_W'(IMG_HDISP);
  localparam logic [POS_W-1:0]  V_END     = POS_W'(IMG_VDISP);
  localparam logic [POS_W-1:0]  POS_MAX   = '1;
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

  cap_state_e        state_q, state_d;
  logic              vsync_q, href_q;
  logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic              frame_done_q, frame_done_d, cap_busy_q, cap_busy_d;
  logic              clear_frame, pk_valid, pk_flush, pk_word_valid;
  logic [WORD_W-1:0] pk_word;
  logic              vs_rise, vs_fall, href_fall, pix_acc;

  assign vs_rise   = ~vsync_q & per_frame_vsync;
  assign vs_fall   = vsync_q & ~per_frame_vsync;
  assign href_fall = href_q & ~per_frame_href;
  assign pix_acc   = per_frame_href & per_frame_clken;

  rgb24_word_packer u_packer (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .clear_i      (clear_frame),
    .pix_valid_i  (pk_valid),
    .pix_i        (pix_data_in),
    .flush_i      (pk_flush),
    .word_valid_c (pk_word_valid),
    .word_c       (pk_word)
  );

  // Capture FSM: frame boundaries, pixel position and geometry checks.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    clear_frame = 1'b0;
    pk_valid    = 1'b0;
    pk_flush    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap_start) begin
          state_d     = ARMED;
          clear_frame = 1'b1;
          line_err_d  = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      ARMED: begin
        // every frame restarts at BASE_ADDR so continuous mode refills the same buffer
        if (vs_rise) begin
          state_d     = ACTIVE;
          clear_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (pix_acc) begin
          if (x_q >= H_END) line_err_d = 1'b1;
          if (y_q >= V_END) frame_err_d = 1'b1;
          pk_valid = (x_q < H_END) && (y_q < V_END);
          if (x_q != POS_MAX) x_d = x_q + POS_W'(1);
        end
        if (href_fall) begin
          if (x_q != H_END) line_err_d = 1'b1;
          if ((x_q != '0) && (y_q != POS_MAX)) y_d = y_q + POS_W'(1);
          x_d = '0;
        end
        if (vs_fall) state_d = FLUSH;
      end
      FLUSH: begin
        pk_flush = 1'b1;
        if (y_q != V_END) frame_err_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = cap_continuous ? ARMED : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear_frame) begin
      x_d = '0;
      y_d = '0;
    end
    frame_done_d = (state_d == DONE);
    cap_busy_d   = (state_d == ARMED) || (state_d == ACTIVE) || (state_d == FLUSH);
  end

  // Write port: register packer words with their address and advance the address.
  always_comb begin
    addr_d    = addr_q;
    wr_en_d   = pk_word_valid;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (clear_frame) begin
      addr_d = ADDR_BASE;
    end else if (pk_word_valid) begin
      addr_d    = addr_q + ADDR_W'(1);
      wr_addr_d = addr_q;
      wr_data_d = pk_word;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= ADDR_BASE;
      wr_addr_q    <= ADDR_BASE;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cap_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= per_frame_vsync;
      href_q       <= per_frame_href;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      frame_done_q <= frame_done_d;
      cap_busy_q   <= cap_busy_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign cap_busy   = cap_busy_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_video_frame_capture.sv
// Bench for video_frame_capture: byte-queue frame model checked every cycle plus literal checks.
module tb_video_frame_capture;

  localparam int H  = 3;
  localparam int V  = 2;
  localparam int AW = 18;

  localparam int M_IDLE = 0, M_ARMED = 1, M_ACTIVE = 2, M_FLUSH = 3, M_DONE = 4;

  logic          clk, rst_n, vsync, href, clken, cap_start, cont;
  logic [23:0]   pix;
  logic          wr_en, cap_busy, frame_done, line_err, frame_err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [10:0]   x_pos, y_pos;

  video_frame_capture #(.IMG_HDISP(H), .IMG_VDISP(V), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .pix_data_in(pix), .cap_start(cap_start),
    .cap_continuous(cont), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .x_pos(x_pos), .y_pos(y_pos), .cap_busy(cap_busy), .frame_done(frame_done),
    .line_err(line_err), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // frame model: a byte stream queue and counters
  int         m_mode, m_x, m_y, m_addr;
  bit         m_pv, m_ph;
  logic [7:0] m_q[$];
  bit         e_wr_en, e_done, e_busy, e_lerr, e_ferr;
  logic [31:0] e_wr_addr, e_wr_data;

  // observed write log
  logic [31:0]   obs_data[256];
  logic [AW-1:0] obs_addr[256];
  int            n_wr = 0;
  int            n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_x = 0; m_y = 0; m_addr = 0; m_pv = 0; m_ph = 0;
    m_q.delete();
    e_wr_en = 0; e_done = 0; e_busy = 0; e_lerr = 0; e_ferr = 0;
    e_wr_addr = 0; e_wr_data = 0;
  endtask

  task automatic frame_clear();
    m_x = 0; m_y = 0; m_addr = 0;
    m_q.delete();
  endtask

  task automatic emit();
    e_wr_data = {m_q[3], m_q[2], m_q[1], m_q[0]};
    repeat (4) void'(m_q.pop_front());
    e_wr_en   = 1;
    e_wr_addr = 32'(m_addr);
    m_addr    = (m_addr + 1) % (1 << AW);
  endtask

  // one clock of the model, using the inputs present at the edge just taken
  task automatic model_step();
    bit vr, vf, hf;
    if (!rst_n) begin
      model_reset();
      return;
    end
    vr = !m_pv && vsync;
    vf = m_pv && !vsync;
    hf = m_ph && !href;
    e_wr_en = 0;
    e_done  = 0;
    case (m_mode)
      M_IDLE: if (cap_start) begin
        m_mode = M_ARMED; e_lerr = 0; e_ferr = 0; frame_clear();
      end
      M_ARMED: if (vr) begin
        m_mode = M_ACTIVE; frame_clear();
      end
      M_ACTIVE: begin
        if (href && clken) begin
          if (m_x >= H) e_lerr = 1;
          if (m_y >= V) e_ferr = 1;
          if (m_x < H && m_y < V) begin
            m_q.push_back(pix[23:16]);
            m_q.push_back(pix[15:8]);
            m_q.push_back(pix[7:0]);
          end
          m_x++;
        end
        if (hf) begin
          if (m_x != H) e_lerr = 1;
          if (m_x != 0) m_y++;
          m_x = 0;
        end
        if (m_q.size() >= 4) emit();
        if (vf) m_mode = M_FLUSH;
      end
      M_FLUSH: begin
        if (m_q.size() > 0) begin
          while (m_q.size() < 4) m_q.push_back(8'h00);
          emit();
        end
        if (m_y != V) e_ferr = 1;
        m_mode = M_DONE;
        e_done = 1;
      end
      default: m_mode = cont ? M_ARMED : M_IDLE;
    endcase
    e_busy = (m_mode == M_ARMED) || (m_mode == M_ACTIVE) || (m_mode == M_FLUSH);
    m_pv = vsync;
    m_ph = href;
  endtask

  // advance one clock, step the model, compare all outputs on the falling edge
  task automatic tick();
    @(negedge clk);
    model_step();
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    if (e_wr_en) begin
      chk("wr_addr", 32'(wr_addr), e_wr_addr);
      chk("wr_data", wr_data, e_wr_data);
    end
    chk("x_pos", 32'(x_pos), 32'(m_x));
    chk("y_pos", 32'(y_pos), 32'(m_y));
    chk("cap_busy", 32'(cap_busy), 32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("line_err", 32'(line_err), 32'(e_lerr));
    chk("frame_err", 32'(frame_err), 32'(e_ferr));
    if (wr_en) begin
      if (n_wr < 256) begin
        obs_data[n_wr] = wr_data;
        obs_addr[n_wr] = wr_addr;
      end
      n_wr++;
    end
    if (frame_done) n_done++;
  endtask

  function automatic logic [23:0] pixval(input int n);
    return {8'(3 * n + 1), 8'(3 * n + 2), 8'(3 * n + 3)};
  endfunction

  task automatic pulse_start();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  // frame with nl lines: first line l0 pixels, the rest lr pixels
  task automatic send_frame(input int nl, input int l0, input int lr);
    int pn = 0;
    vsync = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    repeat (2) tick();
    for (int l = 0; l < nl; l++) begin
      href  = 1'b1;
      clken = 1'b1;
      for (int p = 0; p < ((l == 0) ? l0 : lr); p++) begin
        pix = pixval(pn);
        pn++;
        tick();
      end
      href  = 1'b0;
      clken = 1'b0;
      repeat (2) tick();
    end
    vsync = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, d0;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0;
    cap_start = 1'b0; cont = 1'b0; pix = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_busy", 32'(cap_busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // pixels 010203..0A0B0C split 3+1 across two lines
    w0 = n_wr; d0 = n_done;
    pulse_start();
    send_frame(2, 3, 1);
    chk("t1_writes", 32'(n_wr - w0), 32'd3);
    chk("t1_w0", obs_data[w0], 32'h04030201);
    chk("t1_w1", obs_data[w0 + 1], 32'h08070605);
    chk("t1_w2", obs_data[w0 + 2], 32'h0C0B0A09);
    chk("t1_a2", 32'(obs_addr[w0 + 2]), 32'd2);
    chk("t1_line_err", 32'(line_err), 32'd1);
    chk("t1_frame_err", 32'(frame_err), 32'd0);
    chk("t1_done", 32'(n_done - d0), 32'd1);

    // full 3x2 frame with a flushed residual
    w0 = n_wr; d0 = n_done;
    pulse_start();
    send_frame(2, 3, 3);
    chk("t2_writes", 32'(n_wr - w0), 32'd5);
    chk("t2_w3", obs_data[w0 + 3], 32'h100F0E0D);
    chk("t2_w4", obs_data[w0 + 4], 32'h00001211);
    chk("t2_a4", 32'(obs_addr[w0 + 4]), 32'd4);
    chk("t2_errs", 32'({line_err, frame_err}), 32'd0);
    chk("t2_done", 32'(n_done - d0), 32'd1);
    chk("t2_idle", 32'(cap_busy), 32'd0);

    // single shot: an unarmed frame writes nothing
    w0 = n_wr; d0 = n_done;
    send_frame(2, 3, 3);
    chk("t3_writes", 32'(n_wr - w0), 32'd0);
    chk("t3_done", 32'(n_done - d0), 32'd0);

    // 4-pixel line (last dropped) and a single line: both errors, 1-byte flush
    w0 = n_wr;
    pulse_start();
    send_frame(1, 4, 0);
    chk("t4_writes", 32'(n_wr - w0), 32'd3);
    chk("t4_flush", obs_data[w0 + 2], 32'h00000009);
    chk("t4_line_err", 32'(line_err), 32'd1);
    chk("t4_frame_err", 32'(frame_err), 32'd1);
    pulse_start();
    chk("t4_clr_line", 32'(line_err), 32'd0);
    chk("t4_clr_frame", 32'(frame_err), 32'd0);
    w0 = n_wr;
    send_frame(2, 3, 3);
    chk("t4_rearm_writes", 32'(n_wr - w0), 32'd5);

    // arming in the middle of a frame waits for the next vsync rise
    w0 = n_wr; d0 = n_done;
    vsync = 1'b1;
    repeat (2) tick();
    href = 1'b1; clken = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pix = pixval(p);
      cap_start = (p == 1);
      tick();
    end
    cap_start = 1'b0;
    href = 1'b0; clken = 1'b0;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (4) tick();
    chk("t5_mid_writes", 32'(n_wr - w0), 32'd0);
    chk("t5_mid_busy", 32'(cap_busy), 32'd1);
    send_frame(2, 3, 3);
    chk("t5_next_writes", 32'(n_wr - w0), 32'd5);
    chk("t5_done", 32'(n_done - d0), 32'd1);

    // continuous capture: two back-to-back frames
    w0 = n_wr; d0 = n_done;
    cont = 1'b1;
    pulse_start();
    send_frame(2, 3, 3);
    send_frame(2, 3, 3);
    cont = 1'b0;
    chk("t6_writes", 32'(n_wr - w0), 32'd10);
    chk("t6_done", 32'(n_done - d0), 32'd2);
    chk("t6_f2_addr0", 32'(obs_addr[w0 + 5]), 32'd0);
    chk("t6_f2_last", obs_data[w0 + 9], 32'h00001211);
    chk("t6_rearmed", 32'(cap_busy), 32'd1);

    // reset in the middle of a frame
    vsync = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    repeat (2) tick();
    href = 1'b1; clken = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pix = pixval(p);
      tick();
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t7_wr_en", 32'(wr_en), 32'd0);
    chk("t7_wr_addr", 32'(wr_addr), 32'd0);
    chk("t7_wr_data", wr_data, 32'd0);
    chk("t7_x", 32'(x_pos), 32'd0);
    chk("t7_y", 32'(y_pos), 32'd0);
    chk("t7_busy", 32'(cap_busy), 32'd0);
    chk("t7_flags", 32'({frame_done, line_err, frame_err}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    href = 1'b0; clken = 1'b0; vsync = 1'b0;
    repeat (2) tick();
    w0 = n_wr;
    send_frame(2, 3, 3);
    chk("t7_no_writes", 32'(n_wr - w0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
